// File: rtl/lfsr_mon_pkg.sv
// Shared types and defaults for the LFSR pattern monitor.
// Holds the FSM state encoding, the default pattern and the state decoder.
package lfsr_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  localparam int                   DEF_PAT_W   = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;
  localparam int                   DEF_CNT_W   = 11;

  // The unused encoding 2'd3 falls back to IDLE so a corrupted state re-aligns on the next tick.
  function automatic state_e decode_state(input logic [1:0] raw);
    case (raw)
      2'd1:    return ST_FILL;
      2'd2:    return ST_COUNT;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_seq_monitor_if.sv
// Stream and result-handshake bundle between the LFSR, the monitor and the result sink.
// The master modport is the LFSR/sink side; the slave modport is the monitor.
interface lfsr_seq_monitor_if
  import lfsr_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             sh_en;
  logic             bit_in;
  logic             period_tick;
  logic             result_ready;
  logic             seq_detected;
  logic [CNT_W-1:0] match_count;
  logic [CNT_W-1:0] result_count;
  logic             result_valid;
  logic             overrun;
  logic             saturated;

  modport master (
    output sh_en, bit_in, period_tick, result_ready,
    input  seq_detected, match_count, result_count, result_valid, overrun, saturated
  );

  modport slave (
    input  sh_en, bit_in, period_tick, result_ready,
    output seq_detected, match_count, result_count, result_valid, overrun, saturated
  );

endinterface

// File: rtl/lfsr_seq_monitor_pattern_window.sv
// Serial history of the stream plus the pattern comparator.
// Only the PAT_W-1 most recent bits are stored; the newest bit joins them combinationally.
module pattern_window
  import lfsr_mon_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en_i,
  input  logic detect_en_i,
  input  logic bit_i,
  output logic match_now_o
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] candidate;

  assign candidate   = {hist_q, bit_i};
  assign hist_d      = shift_en_i ? candidate[PAT_W-2:0] : hist_q;
  assign match_now_o = shift_en_i & detect_en_i & (candidate == PATTERN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/lfsr_seq_monitor.sv
// Counts overlapping pattern matches in the LFSR MSB stream per LFSR period and
// publishes each period's count through a one-deep valid/ready result register.
module lfsr_seq_monitor
  import lfsr_mon_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  lfsr_seq_monitor_if.slave   mon
);

  localparam int               FILL_W    = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 2);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d, cur_state;
  logic [FILL_W-1:0] fill_q, fill_d;

  logic              shift_en;
  logic              detect_en;
  logic              match_now;
  logic              close;
  logic              clip;
  logic [CNT_W-1:0]  sum_sat;

  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic              seq_q;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              sat_q, sat_d;

  assign cur_state = decode_state(state_q);
  assign shift_en  = mon.sh_en & ((cur_state == ST_FILL) | (cur_state == ST_COUNT));
  assign detect_en = (cur_state == ST_COUNT);
  assign close     = detect_en & mon.sh_en & mon.period_tick;

  pattern_window #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_window (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en_i  (shift_en),
    .detect_en_i (detect_en),
    .bit_i       (mon.bit_in),
    .match_now_o (match_now)
  );

  // A match arriving while the counter is already full is the only case that clips.
  assign clip    = match_now & (match_q == CNT_MAX);
  assign sum_sat = clip ? CNT_MAX : (match_q + CNT_W'(match_now));

  always_comb begin
    state_d = cur_state;
    fill_d  = fill_q;
    case (cur_state)
      ST_IDLE: begin
        if (mon.sh_en && mon.period_tick) begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
      end
      ST_FILL: begin
        if (mon.sh_en) begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_LAST) begin
            state_d = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        state_d = ST_COUNT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A close takes priority over a transfer: the fresh result is loaded either way,
  // and overrun only flags a result that the sink never took.
  always_comb begin
    match_d  = match_q;
    sat_d    = sat_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (close) begin
      result_d = sum_sat;
      match_d  = '0;
      sat_d    = clip;
      valid_d  = 1'b1;
      if (valid_q && !mon.result_ready) begin
        ovr_d = 1'b1;
      end
    end else begin
      if (detect_en && mon.sh_en) begin
        match_d = sum_sat;
        if (sum_sat == CNT_MAX) begin
          sat_d = 1'b1;
        end
      end
      if (valid_q && mon.result_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      fill_q   <= '0;
      match_q  <= '0;
      result_q <= '0;
      seq_q    <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      result_q <= result_d;
      seq_q    <= match_now;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      sat_q    <= sat_d;
    end
  end

  assign mon.seq_detected = seq_q;
  assign mon.match_count  = match_q;
  assign mon.result_count = result_q;
  assign mon.result_valid = valid_q;
  assign mon.overrun      = ovr_q;
  assign mon.saturated    = sat_q;

endmodule

// File: tb/tb_lfsr_seq_monitor.sv
// Directed and randomized bench for lfsr_seq_monitor with PATTERN=1011, CNT_W=4.
// Expectations come from a bit-history model counting bits seen since the aligning tick.
module tb_lfsr_seq_monitor;

  localparam int PAT_W   = 4;
  localparam int PAT_VAL = 11;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk;
  logic rst_n;

  lfsr_seq_monitor_if #(.CNT_W(CNT_W)) bus ();

  lfsr_seq_monitor #(
    .PAT_W   (PAT_W),
    .PATTERN (4'b1011),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int totalChecks;
  int passedChecks;
  int failedChecks;

  bit mStarted;
  int mBitsSeen;
  int mHist;
  int mCount;
  bit mSat;
  int mResult;
  bit mValid;
  bit mOverrun;
  bit mDet;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passedChecks++;
    else begin
      failedChecks++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mStarted  = 0;
    mBitsSeen = 0;
    mHist     = 0;
    mCount    = 0;
    mSat      = 0;
    mResult   = 0;
    mValid    = 0;
    mOverrun  = 0;
    mDet      = 0;
  endtask

  // Counting is live once PAT_W bits have arrived after the aligning tick.
  task automatic modelStep(input bit sh, input bit b, input bit tick, input bit rdy);
    bit match;
    bit closing;
    int capped;
    match   = 0;
    closing = 0;
    if (!mStarted) begin
      if (sh && tick) begin
        mStarted  = 1;
        mBitsSeen = 0;
      end
    end else if (sh) begin
      mHist = ((mHist << 1) | int'(b)) & ((1 << PAT_W) - 1);
      mBitsSeen++;
      match   = (mBitsSeen >= PAT_W) && (mHist == PAT_VAL);
      closing = tick && (mBitsSeen >= PAT_W);
    end
    capped = (mCount + int'(match) > CNT_MAX) ? CNT_MAX : mCount + int'(match);
    if (closing) begin
      mSat = match && (mCount == CNT_MAX);
      if (mValid && !rdy) mOverrun = 1;
      mResult = capped;
      mValid  = 1;
      mCount  = 0;
    end else begin
      mCount = capped;
      if (mCount == CNT_MAX) mSat = 1;
      if (mValid && rdy) mValid = 0;
    end
    mDet = match;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_seq_detected"}, bus.seq_detected, mDet);
    checkVal({tag, "_match_count"}, bus.match_count, mCount);
    checkVal({tag, "_result_count"}, bus.result_count, mResult);
    checkVal({tag, "_result_valid"}, bus.result_valid, mValid);
    checkVal({tag, "_overrun"}, bus.overrun, mOverrun);
    checkVal({tag, "_saturated"}, bus.saturated, mSat);
  endtask

  task automatic applyStimulus(input bit sh, input bit b, input bit tick, input bit rdy,
                               input string tag);
    bus.sh_en        = sh;
    bus.bit_in       = b;
    bus.period_tick  = tick;
    bus.result_ready = rdy;
    modelStep(sh, b, tick, rdy);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic streamBits(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b1, bits[i], 1'b0, 1'b0, tag);
    end
  endtask

  // Reset is asserted between edges and checked before any clock edge arrives.
  task automatic doReset(input string tag);
    rst_n            = 1'b0;
    bus.sh_en        = 1'b0;
    bus.bit_in       = 1'b0;
    bus.period_tick  = 1'b0;
    bus.result_ready = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    totalChecks  = 0;
    passedChecks = 0;
    failedChecks = 0;
    rst_n = 1'b0;
    bus.sh_en        = 1'b0;
    bus.bit_in       = 1'b0;
    bus.period_tick  = 1'b0;
    bus.result_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    doReset("reset");

    $display("[TB] overlapping detection after aligning tick");
    applyStimulus(1, 0, 1, 0, "t1_tick");
    streamBits(32'b1011011, 7, "t1_stream");
    checkVal("t1_match_count_const", bus.match_count, 2);

    $display("[TB] period close and handshake");
    applyStimulus(1, 0, 1, 0, "t2_close");
    checkVal("t2_result_const", bus.result_count, 2);
    checkVal("t2_valid_const", bus.result_valid, 1);
    applyStimulus(1, 0, 0, 1, "t2_ready");
    checkVal("t2_valid_drop_const", bus.result_valid, 0);

    $display("[TB] match on the tick cycle");
    streamBits(32'b101101101, 9, "t3_stream");
    applyStimulus(1, 1, 1, 0, "t3_close");
    checkVal("t3_result_const", bus.result_count, 3);
    checkVal("t3_match_const", bus.match_count, 0);
    applyStimulus(0, 0, 0, 1, "t3_consume");

    $display("[TB] no detection in IDLE or FILL");
    doReset("t4_reset");
    streamBits(32'b1011, 4, "t4_idle");
    applyStimulus(1, 1, 1, 0, "t4_align");
    applyStimulus(1, 1, 1, 0, "t4_fill_tick0");
    applyStimulus(1, 0, 1, 0, "t4_fill_tick1");
    applyStimulus(1, 1, 0, 0, "t4_fill_last");
    checkVal("t4_no_result_const", bus.result_valid, 0);
    applyStimulus(1, 1, 0, 0, "t4_first_match");
    checkVal("t4_det_const", bus.seq_detected, 1);

    $display("[TB] saturation");
    for (int i = 0; i < 20; i++) begin
      streamBits(32'b011, 3, "t5_stream");
    end
    checkVal("t5_match_sat_const", bus.match_count, 15);
    checkVal("t5_sat_const", bus.saturated, 1);
    applyStimulus(1, 0, 1, 1, "t5_close");
    checkVal("t5_result_const", bus.result_count, 15);
    checkVal("t5_sat_clear_const", bus.saturated, 0);

    $display("[TB] overrun, gaps and async reset");
    streamBits(32'b11, 2, "t6_stream");
    applyStimulus(1, 0, 1, 0, "t6_close");
    checkVal("t6_overrun_const", bus.overrun, 1);
    checkVal("t6_result_const", bus.result_count, 1);
    repeat (3) applyStimulus(0, 1, 1, 1'b0, "t6_gap");
    checkVal("t6_gap_result_const", bus.result_count, 1);
    streamBits(32'b1011, 4, "t6_pre_reset");
    doReset("t6_async_reset");

    $display("[TB] randomized stream");
    applyStimulus(1, 0, 1, 0, "rnd_align");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        doReset("rnd_reset");
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
